ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage of the in-order pipeline, feeding decode (DE).
- Holds the fetch PC and MSR and issues 64-bit reads on the instruction EMI port.
- Selects the 32-bit instruction word and presents {valid, pc, msr, instr, fault} to DE.
- Accepts redirects (new PC/MSR) from WB and MEM, annuls from EXE/WB, honours DE back-pressure, and raises an IRQ fault.

Parameters:
- RESET_PC, 32'h0000_0100, fetch address after reset.
- RESET_MSR, 32'h0, MSR after reset.
- MSR_EE_BIT, 15, MSR bit that enables external interrupts.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- IRQ  in  1  level external interrupt request
- wb_newpc  in  32  redirect PC from WB
- wb_newmsr  in  32  redirect MSR from WB
- wb_newpcmsr_valid  in  1  WB redirect strobe (PC and MSR)
- exe_annul  in  1  discard in-flight fetch and wait for a redirect
- wb_annul  in  1  as exe_annul
- mem_newpc  in  32  redirect PC from MEM
- mem_newmsr  in  32  new MSR from MEM
- mem_newpc_valid  in  1  MEM PC redirect strobe
- mem_newmsr_valid  in  1  MEM MSR update strobe
- decode_stall  in  1  DE cannot accept; hold outputs
- ifetch_valid  out  1  output bundle valid
- ifetch_fault  out  4  fault code (0 = none)
- ifetch_pc  out  32  PC of presented instruction
- ifetch_msr  out  32  MSR at fetch
- ifetch_instr  out  32  instruction word
- emi_if_address  out  32  read address, 8-byte granule (bits [2:0] ignored by memory)
- emi_if_req  out  1  read request
- emi_if_rdata  in  64  read data; returned at the edge after the request
- emi_if_valid  in  1  rdata valid

Behaviour:
- State: fpc (next fetch PC), msr, out_pc, out_msr, out_valid, out_fault, mode ∈ {RUN, WAIT_REDIRECT}.
- Reset (async, reset=0):
  - fpc=RESET_PC, msr=RESET_MSR, mode=RUN.
  - out_valid=0, out_fault=0, out_pc=0, out_msr=0.
  - All outputs are 0 except emi_if_address=RESET_PC and emi_if_req=1.
- Address and request:
  - emi_if_address = (out_valid & (decode_stall | !emi_if_valid)) ? out_pc : fpc.
  - Re-presenting out_pc while held keeps rdata stable.
  - emi_if_req = (mode==RUN) | out_valid.
- Instruction select: ifetch_instr = out_pc[2] ? rdata[63:32] : rdata[31:0].
- Output: ifetch_valid = out_valid & emi_if_valid. ifetch_pc=out_pc, ifetch_msr=out_msr, ifetch_fault=out_fault.
- Advance: on an edge in RUN with no stall, no annul, no redirect, and (emi_if_valid or !out_valid):
  - out_pc<=fpc, out_msr<=msr, out_valid<=1, fpc<=fpc+4 (mod 2^32).
  - Throughput is 1 instruction/cycle; the first instruction is valid one edge after reset release.
- Hold: while decode_stall=1 or (out_valid & !emi_if_valid), all registers hold. The same instruction stays presented.
- Annul (exe_annul | wb_annul), no redirect in the same cycle: out_valid<=0, mode<=WAIT_REDIRECT. No requests until a redirect.
- Redirect:
  - Trigger: wb_newpcmsr_valid, else mem_newpc_valid. WB has priority when both are set.
  - Action: fpc<=new PC, out_valid<=0, mode<=RUN.
  - WB also loads msr<=wb_newmsr.
  - The redirect overrides any annul and any stall in the same cycle.
  - The first redirected instruction is valid one edge after the redirect edge.
- MSR update: mem_newmsr_valid loads msr<=mem_newmsr. Ignored when wb_newpcmsr_valid is set in the same cycle.
- IRQ, checked on an advance edge: if IRQ & msr[MSR_EE_BIT] then:
  - out_pc<=fpc, out_fault<=FAULT_IRQ, out_valid<=1, mode<=WAIT_REDIRECT.
  - fpc is not incremented.
  - out_fault clears on the next redirect.
- Fault encoding: FAULT_NONE=0, FAULT_IRQ=1, FAULT_ISI=2 (reserved, never driven).
- The decode_stall condition gates only advances; annul and redirect always act.

Decomposition:
- Shared package/header holds the FAULT_* 4-bit codes, RESET_PC/RESET_MSR defaults, and MSR_EE_BIT.
- Single flat module; no sub-module.

Test Plan:
- Reset release, then sequential run with memory word {magic(2i+1), magic(2i)} at index i:
  - valid at 0x100, 0x104, 0x108 on consecutive clocks.
  - instr = magic(addr/4), fault=0.
- Hold decode_stall=1 for 5 cycles while 0x108 is presented:
  - output stays valid at 0x108 with magic(0x42) throughout.
  - After release: 0x10c, then 0x110 on consecutive clocks.
- exe_annul for 1 cycle, then wb_newpc=0x60 with wb_newpcmsr_valid for 1 cycle:
  - valid deasserted with no req after the annul.
  - 0x60 valid one edge after the redirect, then 0x64 and 0x68.
- Simultaneous wb and mem redirects (0x200 / 0x300) → fetch continues from 0x200. mem_newpc alone → 0x300.
- emi_if_valid low for 3 cycles mid-stream → ifetch_valid=0 and PC holds; stream resumes without skipping or duplicating.
- MSR=0x8000 via wb redirect, then IRQ=1 → one valid output with fault=1 and pc = next fetch PC, then no fetch until a redirect. With IRQ and MSR=0 → no effect.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fault_e   : 4-bit fault codes carried alongside each fetched instruction
//   - mode_e    : fetch mode (running, or parked until a redirect arrives)
//   - reset defaults for the fetch PC and MSR, and the MSR external-interrupt
//     enable bit position
// ----------------------------------------------------------------------------
package ifetch_pkg;

  typedef enum logic [3:0] {
    FAULT_NONE = 4'd0,
    FAULT_IRQ  = 4'd1,
    FAULT_ISI  = 4'd2   // reserved, never produced by this stage
  } fault_e;

  typedef enum logic {
    MODE_RUN           = 1'b0,
    MODE_WAIT_REDIRECT = 1'b1
  } mode_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0100;
  localparam logic [31:0] RESET_MSR_DEFAULT  = 32'h0000_0000;
  localparam int          MSR_EE_BIT_DEFAULT = 15;

endpackage : ifetch_pkg

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch
// Instruction-fetch stage. Holds the fetch PC and MSR, issues 64-bit reads on
// the instruction EMI port, selects the 32-bit word and presents
// {valid, pc, msr, instr, fault} to decode.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   IRQ                         level external interrupt request
//   wb_newpc/_newmsr/_valid     WB redirect (PC and MSR), highest priority
//   mem_newpc/_valid            MEM PC redirect
//   mem_newmsr/_valid           MEM MSR update
//   exe_annul, wb_annul         drop the presented fetch, park until redirect
//   decode_stall                decode cannot accept; hold the presented word
//   ifetch_*                    bundle presented to decode
//   emi_if_address/_req         instruction read request (8-byte granule)
//   emi_if_rdata/_valid         read data, returned on the edge after request
// ----------------------------------------------------------------------------
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] RESET_MSR  = RESET_MSR_DEFAULT,
  parameter int          MSR_EE_BIT = MSR_EE_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRQ,
  input  logic [31:0] wb_newpc,
  input  logic [31:0] wb_newmsr,
  input  logic        wb_newpcmsr_valid,
  input  logic        exe_annul,
  input  logic        wb_annul,
  input  logic [31:0] mem_newpc,
  input  logic [31:0] mem_newmsr,
  input  logic        mem_newpc_valid,
  input  logic        mem_newmsr_valid,
  input  logic        decode_stall,
  output logic        ifetch_valid,
  output logic [3:0]  ifetch_fault,
  output logic [31:0] ifetch_pc,
  output logic [31:0] ifetch_msr,
  output logic [31:0] ifetch_instr,
  output logic [31:0] emi_if_address,
  output logic        emi_if_req,
  input  logic [63:0] emi_if_rdata,
  input  logic        emi_if_valid
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] msr_q, msr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_msr_q, out_msr_d;
  logic        out_valid_q, out_valid_d;
  fault_e      out_fault_q, out_fault_d;
  mode_e       mode_q, mode_d;

  logic redirect;
  logic annul;
  logic can_accept;
  logic irq_take;

  assign redirect   = wb_newpcmsr_valid | mem_newpc_valid;
  assign annul      = exe_annul | wb_annul;
  // The presented slot can move on once decode takes it, or if it is empty.
  assign can_accept = !decode_stall && (emi_if_valid || !out_valid_q);
  assign irq_take   = IRQ & msr_q[MSR_EE_BIT];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q       <= RESET_PC;
      msr_q       <= RESET_MSR;
      out_pc_q    <= '0;
      out_msr_q   <= '0;
      out_valid_q <= 1'b0;
      out_fault_q <= FAULT_NONE;
      mode_q      <= MODE_RUN;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational process.
      fpc_q       <= fpc_d;
      msr_q       <= msr_d;
      out_pc_q    <= out_pc_d;
      out_msr_q   <= out_msr_d;
      out_valid_q <= out_valid_d;
      out_fault_q <= out_fault_d;
      mode_q      <= mode_d;
    end
  end

  // Next-state logic. Priority: redirect > annul > advance/consume > hold.
  always_comb begin
    // NOTE: every target defaults to its current value first, so no path
    // through the branches below can leave a signal unassigned (no latches).
    fpc_d       = fpc_q;
    msr_d       = msr_q;
    out_pc_d    = out_pc_q;
    out_msr_d   = out_msr_q;
    out_valid_d = out_valid_q;
    out_fault_d = out_fault_q;
    mode_d      = mode_q;

    // MSR updates are independent of the fetch flow; WB wins over MEM.
    if (wb_newpcmsr_valid) begin
      msr_d = wb_newmsr;
    end else if (mem_newmsr_valid) begin
      msr_d = mem_newmsr;
    end

    if (redirect) begin
      fpc_d       = wb_newpcmsr_valid ? wb_newpc : mem_newpc;
      out_valid_d = 1'b0;
      out_fault_d = FAULT_NONE;
      mode_d      = MODE_RUN;
    end else if (annul) begin
      out_valid_d = 1'b0;
      mode_d      = MODE_WAIT_REDIRECT;
    end else if (can_accept) begin
      if (mode_q == MODE_RUN) begin
        out_pc_d    = fpc_q;
        out_msr_d   = msr_q;
        out_valid_d = 1'b1;
        if (irq_take) begin
          // Present the interrupted PC as a faulting slot and park; fpc is
          // left pointing at it so the handler's return target is exact.
          out_fault_d = FAULT_IRQ;
          mode_d      = MODE_WAIT_REDIRECT;
        end else begin
          fpc_d = fpc_q + 32'd4;
        end
      end else begin
        // Parked: decode has taken the last slot (e.g. the IRQ fault), so
        // it is retired and nothing further is issued until a redirect.
        out_valid_d = 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    // While a slot is held, keep re-reading its granule so rdata stays stable.
    if (out_valid_q && (decode_stall || !emi_if_valid)) begin
      emi_if_address = out_pc_q;
    end else begin
      emi_if_address = fpc_q;
    end
    emi_if_req   = (mode_q == MODE_RUN) || out_valid_q;
    ifetch_instr = out_pc_q[2] ? emi_if_rdata[63:32] : emi_if_rdata[31:0];
    ifetch_valid = out_valid_q & emi_if_valid;
    ifetch_pc    = out_pc_q;
    ifetch_msr   = out_msr_q;
    ifetch_fault = out_fault_q;
  end

endmodule : ifetch

// File: tb/tb_ifetch.sv
// ----------------------------------------------------------------------------
// tb_ifetch
// Directed walk through reset, streaming, stall, annul/redirect, redirect
// priority, memory back-pressure and IRQ, followed by a randomized phase in
// which the accepted instruction stream is compared against a stream-level
// reference (next expected PC, advanced by 4 per accepted word and replaced
// on every redirect).
// ----------------------------------------------------------------------------
module tb_ifetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IRQ = 1'b0;
  logic [31:0] wb_newpc = '0;
  logic [31:0] wb_newmsr = '0;
  logic        wb_newpcmsr_valid = 1'b0;
  logic        exe_annul = 1'b0;
  logic        wb_annul = 1'b0;
  logic [31:0] mem_newpc = '0;
  logic [31:0] mem_newmsr = '0;
  logic        mem_newpc_valid = 1'b0;
  logic        mem_newmsr_valid = 1'b0;
  logic        decode_stall = 1'b0;
  logic        ifetch_valid;
  logic [3:0]  ifetch_fault;
  logic [31:0] ifetch_pc;
  logic [31:0] ifetch_msr;
  logic [31:0] ifetch_instr;
  logic [31:0] emi_if_address;
  logic        emi_if_req;
  logic [63:0] emi_if_rdata;
  logic        emi_if_valid;

  logic        mem_block = 1'b0;   // forces the memory to withhold data

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk              (clk),
    .reset            (reset),
    .IRQ              (IRQ),
    .wb_newpc         (wb_newpc),
    .wb_newmsr        (wb_newmsr),
    .wb_newpcmsr_valid(wb_newpcmsr_valid),
    .exe_annul        (exe_annul),
    .wb_annul         (wb_annul),
    .mem_newpc        (mem_newpc),
    .mem_newmsr       (mem_newmsr),
    .mem_newpc_valid  (mem_newpc_valid),
    .mem_newmsr_valid (mem_newmsr_valid),
    .decode_stall     (decode_stall),
    .ifetch_valid     (ifetch_valid),
    .ifetch_fault     (ifetch_fault),
    .ifetch_pc        (ifetch_pc),
    .ifetch_msr       (ifetch_msr),
    .ifetch_instr     (ifetch_instr),
    .emi_if_address   (emi_if_address),
    .emi_if_req       (emi_if_req),
    .emi_if_rdata     (emi_if_rdata),
    .emi_if_valid     (emi_if_valid)
  );

  // Instruction word stored at word index n.
  function automatic logic [31:0] magic(input logic [31:0] n);
    return n * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // Memory: granule i holds {magic(2i+1), magic(2i)}, returned one edge later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      emi_if_rdata <= '0;
      emi_if_valid <= 1'b0;
    end else if (emi_if_req && !mem_block) begin
      emi_if_rdata <= {magic({2'b00, emi_if_address[31:3], 1'b1}),
                       magic({2'b00, emi_if_address[31:3], 1'b0})};
      emi_if_valid <= 1'b1;
    end else begin
      emi_if_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presented slot is a valid, fault-free instruction at pc.
  task automatic expect_instr(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(ifetch_valid), 64'(1'b1));
    check({tag, "_pc"},    64'(ifetch_pc),    64'(pc));
    check({tag, "_instr"}, 64'(ifetch_instr), 64'(magic(pc >> 2)));
    check({tag, "_fault"}, 64'(ifetch_fault), 64'(4'd0));
  endtask

  task automatic wb_redirect(input logic [31:0] pc, input logic [31:0] msr);
    wb_newpc = pc;
    wb_newmsr = msr;
    wb_newpcmsr_valid = 1'b1;
    tick();
    wb_newpcmsr_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] npc;
    int          gap;
    int          max_gap;
    int          accepted;
    logic        stall_c;
    logic        wb_c;
    logic        mem_c;

    // ---- reset state ----
    repeat (2) tick();
    check("rst_valid",   64'(ifetch_valid),   64'(1'b0));
    check("rst_addr",    64'(emi_if_address), 64'(32'h100));
    check("rst_req",     64'(emi_if_req),     64'(1'b1));
    check("rst_pc",      64'(ifetch_pc),      64'(32'h0));
    check("rst_msr",     64'(ifetch_msr),     64'(32'h0));
    check("rst_fault",   64'(ifetch_fault),   64'(4'd0));
    check("rst_instr",   64'(ifetch_instr),   64'(32'h0));

    // ---- sequential run ----
    reset = 1'b1;
    tick(); expect_instr("run0", 32'h100);
    tick(); expect_instr("run1", 32'h104);
    tick(); expect_instr("run2", 32'h108);
    check("run2_magic", 64'(ifetch_instr), 64'(magic(32'h42)));

    // ---- decode stall for 5 cycles ----
    decode_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_instr("stall", 32'h108);
    end
    decode_stall = 1'b0;
    tick(); expect_instr("unstall0", 32'h10c);
    tick(); expect_instr("unstall1", 32'h110);

    // ---- annul then WB redirect ----
    exe_annul = 1'b1;
    tick();
    exe_annul = 1'b0;
    check("annul_valid", 64'(ifetch_valid), 64'(1'b0));
    check("annul_req",   64'(emi_if_req),   64'(1'b0));
    tick();
    check("annul_req_hold", 64'(emi_if_req), 64'(1'b0));
    wb_redirect(32'h60, 32'h0);
    check("redir_gap", 64'(ifetch_valid), 64'(1'b0));
    tick(); expect_instr("redir0", 32'h60);
    tick(); expect_instr("redir1", 32'h64);
    tick(); expect_instr("redir2", 32'h68);

    // ---- WB and MEM redirect together: WB wins ----
    wb_newpc = 32'h200; wb_newmsr = 32'h0; wb_newpcmsr_valid = 1'b1;
    mem_newpc = 32'h300; mem_newpc_valid = 1'b1;
    tick();
    wb_newpcmsr_valid = 1'b0; mem_newpc_valid = 1'b0;
    tick(); expect_instr("prio0", 32'h200);
    tick(); expect_instr("prio1", 32'h204);
    mem_newpc = 32'h300; mem_newpc_valid = 1'b1;
    tick();
    mem_newpc_valid = 1'b0;
    tick(); expect_instr("mem0", 32'h300);

    // ---- memory withholds data for 3 cycles ----
    mem_block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("blk_valid", 64'(ifetch_valid), 64'(1'b0));
      check("blk_pc",    64'(ifetch_pc),    64'(32'h304));
    end
    mem_block = 1'b0;
    tick(); expect_instr("resume0", 32'h304);
    tick(); expect_instr("resume1", 32'h308);

    // ---- IRQ with EE set ----
    wb_redirect(32'h400, 32'h8000);
    tick(); expect_instr("ee0", 32'h400);
    check("ee0_msr", 64'(ifetch_msr), 64'(32'h8000));
    IRQ = 1'b1;
    tick();
    IRQ = 1'b0;
    check("irq_valid", 64'(ifetch_valid), 64'(1'b1));
    check("irq_pc",    64'(ifetch_pc),    64'(32'h404));
    check("irq_fault", 64'(ifetch_fault), 64'(4'd1));
    tick();
    check("irq_after_valid", 64'(ifetch_valid), 64'(1'b0));
    check("irq_after_req",   64'(emi_if_req),   64'(1'b0));
    tick();
    check("irq_park_req", 64'(emi_if_req), 64'(1'b0));
    wb_redirect(32'h500, 32'h0);
    check("irq_clr_fault", 64'(ifetch_fault), 64'(4'd0));
    tick(); expect_instr("post_irq", 32'h500);

    // ---- IRQ with EE clear has no effect ----
    IRQ = 1'b1;
    tick(); expect_instr("noee0", 32'h504);
    tick(); expect_instr("noee1", 32'h508);
    IRQ = 1'b0;

    // ---- randomized stream against the stream-level reference ----
    wb_redirect(32'h800, 32'h0);
    exp_pc = 32'h800;
    gap = 0;
    max_gap = 0;
    accepted = 0;
    for (int i = 0; i < 400; i++) begin
      stall_c   = ($urandom % 4) == 0;
      wb_c      = ($urandom % 40) == 0;
      mem_c     = !wb_c && (($urandom % 40) == 0);
      mem_block = ($urandom % 5) == 0;
      npc       = 32'($urandom_range(0, 1023)) << 2;

      // Decode takes the presented word this edge unless stalled or flushed.
      if (ifetch_valid && !stall_c && !wb_c && !mem_c) begin
        check("rnd_pc",    64'(ifetch_pc),    64'(exp_pc));
        check("rnd_instr", 64'(ifetch_instr), 64'(magic(exp_pc >> 2)));
        check("rnd_fault", 64'(ifetch_fault), 64'(4'd0));
        exp_pc = exp_pc + 32'd4;
        accepted++;
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (wb_c || mem_c) exp_pc = npc;

      decode_stall      = stall_c;
      wb_newpc          = npc;
      wb_newmsr         = 32'h0;
      wb_newpcmsr_valid = wb_c;
      mem_newpc         = npc;
      mem_newpc_valid   = mem_c;
      tick();
    end
    decode_stall = 1'b0; wb_newpcmsr_valid = 1'b0; mem_newpc_valid = 1'b0;
    mem_block = 1'b0;
    check("rnd_progress", 64'(max_gap <= 40), 64'(1'b1));
    check("rnd_accepted", 64'(accepted > 100), 64'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ifetch
